// File: rtl/io_mux_ctrl.sv
// I/O port controller: maps a flat I/O address space onto NUM_PORTS byte ports,
// each multiplexed over CH_PER_PORT channels, with a select/settle/transfer sequence.
module io_mux_ctrl #(
    parameter int DATA_W      = 8,
    parameter int NUM_PORTS   = 2,
    parameter int CH_PER_PORT = 8,
    parameter int ADDR_W      = 16,
    parameter int SETTLE_CYC  = 3,
    localparam int SEL_W      = $clog2(CH_PER_PORT)
) (
    input  logic                          clk,
    input  logic                          rst_n,
    input  logic                          req,
    input  logic                          we,
    input  logic [ADDR_W-1:0]             ioaddr,
    input  logic [DATA_W-1:0]             wdata,
    output logic [DATA_W-1:0]             rdata,
    output logic                          ack,
    output logic                          err,
    output logic                          busy,
    output logic [NUM_PORTS*SEL_W-1:0]    pin_sel,
    output logic [NUM_PORTS*DATA_W-1:0]   pin_out,
    output logic [NUM_PORTS-1:0]          pin_oe,
    input  logic [NUM_PORTS*DATA_W-1:0]   pin_in
);

    localparam int NUM_ADDR = NUM_PORTS * CH_PER_PORT;
    localparam int PORT_W   = (NUM_PORTS > 1) ? $clog2(NUM_PORTS) : 1;
    localparam int CNT_W    = $clog2(SETTLE_CYC);

    typedef enum logic [1:0] {IDLE, SELECT, XFER, DONE} state_t;

    state_t                  state_reg, state_next;
    logic [CNT_W-1:0]        cnt_reg, cnt_next;
    logic                    we_reg;
    logic [DATA_W-1:0]       wdata_reg;
    logic [PORT_W-1:0]       port_reg;
    logic                    err_reg;
    logic                    pend_reg;
    logic [DATA_W-1:0]       rdata_reg;
    logic [NUM_PORTS*DATA_W-1:0] pin_in_sync;

    logic                    addr_valid;
    logic [PORT_W-1:0]       port_dec;
    logic                    accept;
    logic                    xfer_enter;

    assign addr_valid = (ioaddr < ADDR_W'(NUM_ADDR));
    assign port_dec   = PORT_W'(ioaddr >> SEL_W);
    // An out-of-range request is held pending for one cycle so its ack lands
    // one cycle after the accept edge, like the registered decode of a real access.
    assign accept     = (state_reg == IDLE) && !pend_reg && req;
    assign xfer_enter = (state_reg == SELECT) && (state_next == XFER);

    always_comb begin
        state_next = state_reg;
        cnt_next   = cnt_reg;
        case (state_reg)
            IDLE: begin
                if (pend_reg) begin
                    state_next = DONE;
                end else if (req && addr_valid) begin
                    state_next = SELECT;
                    cnt_next   = '0;
                end
            end
            SELECT: begin
                if (cnt_reg == CNT_W'(SETTLE_CYC - 1)) begin
                    state_next = XFER;
                end else begin
                    cnt_next = cnt_reg + 1'b1;
                end
            end
            XFER:    state_next = DONE;
            DONE:    state_next = IDLE;
            default: state_next = IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state_reg <= IDLE;
            cnt_reg   <= '0;
            we_reg    <= 1'b0;
            wdata_reg <= '0;
            port_reg  <= '0;
            err_reg   <= 1'b0;
            pend_reg  <= 1'b0;
            rdata_reg <= '0;
        end else begin
            state_reg <= state_next;
            cnt_reg   <= cnt_next;
            pend_reg  <= accept && !addr_valid;
            if (accept) begin
                we_reg    <= we;
                wdata_reg <= wdata;
                port_reg  <= port_dec;
                err_reg   <= !addr_valid;
            end
            if (state_reg == XFER && !we_reg) begin
                rdata_reg <= pin_in_sync[port_reg*DATA_W +: DATA_W];
            end
        end
    end

    genvar gi;
    generate
        for (gi = 0; gi < NUM_PORTS; gi++) begin : g_port
            logic [SEL_W-1:0]  sel_reg;
            logic [DATA_W-1:0] out_reg;
            logic [DATA_W-1:0] sync1_reg;
            logic [DATA_W-1:0] sync2_reg;

            always_ff @(posedge clk) begin
                if (!rst_n) begin
                    sel_reg   <= '0;
                    out_reg   <= '0;
                    sync1_reg <= '0;
                    sync2_reg <= '0;
                end else begin
                    sync1_reg <= pin_in[gi*DATA_W +: DATA_W];
                    sync2_reg <= sync1_reg;
                    if (accept && addr_valid && port_dec == PORT_W'(gi)) begin
                        sel_reg <= ioaddr[SEL_W-1:0];
                    end
                    // Loaded on entry to XFER so the data is on the pins while oe is high,
                    // and left in place afterwards.
                    if (xfer_enter && we_reg && port_reg == PORT_W'(gi)) begin
                        out_reg <= wdata_reg;
                    end
                end
            end

            assign pin_sel[gi*SEL_W +: SEL_W]      = sel_reg;
            assign pin_out[gi*DATA_W +: DATA_W]    = out_reg;
            assign pin_in_sync[gi*DATA_W +: DATA_W] = sync2_reg;
            assign pin_oe[gi] = (state_reg == XFER) && we_reg && (port_reg == PORT_W'(gi));
        end
    endgenerate

    assign rdata = rdata_reg;
    assign ack   = (state_reg == DONE);
    assign err   = (state_reg == DONE) && err_reg;
    assign busy  = (state_reg != IDLE);

endmodule

// File: tb/tb_io_mux_ctrl.sv
// Scoreboard bench for io_mux_ctrl: default instance plus a 3-port/4-channel/settle-2 instance.
module tb_io_mux_ctrl;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic rst_n;

    logic        req0, we0;
    logic [15:0] ioaddr0;
    logic [7:0]  wdata0;
    logic [15:0] pin_in0;
    logic [7:0]  rdata0;
    logic        ack0, err0, busy0;
    logic [5:0]  pin_sel0;
    logic [15:0] pin_out0;
    logic [1:0]  pin_oe0;

    logic        req1, we1;
    logic [15:0] ioaddr1;
    logic [7:0]  wdata1;
    logic [23:0] pin_in1;
    logic [7:0]  rdata1;
    logic        ack1, err1, busy1;
    logic [5:0]  pin_sel1;
    logic [23:0] pin_out1;
    logic [2:0]  pin_oe1;

    io_mux_ctrl u0 (
        .clk(clk), .rst_n(rst_n), .req(req0), .we(we0), .ioaddr(ioaddr0), .wdata(wdata0),
        .rdata(rdata0), .ack(ack0), .err(err0), .busy(busy0),
        .pin_sel(pin_sel0), .pin_out(pin_out0), .pin_oe(pin_oe0), .pin_in(pin_in0)
    );

    io_mux_ctrl #(.NUM_PORTS(3), .CH_PER_PORT(4), .SETTLE_CYC(2)) u1 (
        .clk(clk), .rst_n(rst_n), .req(req1), .we(we1), .ioaddr(ioaddr1), .wdata(wdata1),
        .rdata(rdata1), .ack(ack1), .err(err1), .busy(busy1),
        .pin_sel(pin_sel1), .pin_out(pin_out1), .pin_oe(pin_oe1), .pin_in(pin_in1)
    );

    int errors = 0;
    int checks = 0;
    int cyc = 0;
    always @(posedge clk) cyc <= cyc + 1;

    logic [8:0] exp_q0[$];
    logic [8:0] exp_q1[$];
    int ack_cnt0 = 0, ack_cnt1 = 0;
    int last_ack0 = 0, prev_ack0 = 0, last_ack1 = 0;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
        end
    endtask

    // Monitors: pop the expected {err, rdata} whenever a DUT presents ack.
    always @(negedge clk) begin
        if (ack0) begin
            logic [8:0] e;
            prev_ack0 = last_ack0;
            last_ack0 = cyc;
            ack_cnt0++;
            $display("u0 ack at cycle %0d: rdata=0x%0h err=%0b", cyc, rdata0, err0);
            if (exp_q0.size() == 0) begin
                checks++;
                errors++;
                $display("FAIL u0_unexpected_ack: rdata=0x%0h err=%0b, expected no ack", rdata0, err0);
            end else begin
                e = exp_q0.pop_front();
                check("u0_rdata", 32'(rdata0), 32'(e[7:0]));
                check("u0_err", 32'(err0), 32'(e[8]));
            end
        end
    end

    always @(negedge clk) begin
        if (ack1) begin
            logic [8:0] e;
            last_ack1 = cyc;
            ack_cnt1++;
            $display("u1 ack at cycle %0d: rdata=0x%0h err=%0b", cyc, rdata1, err1);
            if (exp_q1.size() == 0) begin
                checks++;
                errors++;
                $display("FAIL u1_unexpected_ack: rdata=0x%0h err=%0b, expected no ack", rdata1, err1);
            end else begin
                e = exp_q1.pop_front();
                check("u1_rdata", 32'(rdata1), 32'(e[7:0]));
                check("u1_err", 32'(err1), 32'(e[8]));
            end
        end
    end

    // Called at a negedge; returns at the negedge of the cycle after the accept edge.
    task automatic issue0(input logic w, input logic [15:0] a, input logic [7:0] d,
                          input logic hold, output int t0);
        req0 = 1'b1; we0 = w; ioaddr0 = a; wdata0 = d;
        @(negedge clk);
        t0 = cyc;
        if (!hold) req0 = 1'b0;
    endtask

    task automatic issue1(input logic w, input logic [15:0] a, input logic [7:0] d, output int t0);
        req1 = 1'b1; we1 = w; ioaddr1 = a; wdata1 = d;
        @(negedge clk);
        t0 = cyc;
        req1 = 1'b0;
    endtask

    task automatic wait_ack0(input int prev, input int t0, input int lat, input string name);
        int n = 0;
        #1;
        while (ack_cnt0 == prev && n < 20) begin
            @(negedge clk); #1; n++;
        end
        if (ack_cnt0 == prev) begin
            checks++; errors++;
            $display("FAIL %s: no ack within 20 cycles, expected ack at latency %0d", name, lat);
        end else begin
            check(name, 32'(last_ack0 - t0), 32'(lat));
        end
    endtask

    task automatic wait_ack1(input int prev, input int t0, input int lat, input string name);
        int n = 0;
        #1;
        while (ack_cnt1 == prev && n < 20) begin
            @(negedge clk); #1; n++;
        end
        if (ack_cnt1 == prev) begin
            checks++; errors++;
            $display("FAIL %s: no ack within 20 cycles, expected ack at latency %0d", name, lat);
        end else begin
            check(name, 32'(last_ack1 - t0), 32'(lat));
        end
    endtask

    initial begin
        #100000;
        $display("FAIL timeout: simulation did not finish, errors=%0d", errors);
        $fatal(1, "timeout");
    end

    initial begin
        int t0, prev;
        logic oe_bad;
        rst_n = 1'b0;
        req0 = 1'b0; we0 = 1'b0; ioaddr0 = '0; wdata0 = '0; pin_in0 = 16'h9E3C;
        req1 = 1'b0; we1 = 1'b0; ioaddr1 = '0; wdata1 = '0; pin_in1 = 24'h5A2211;
        repeat (3) @(negedge clk);
        check("rst_rdata", 32'(rdata0), 0);
        check("rst_ack", 32'(ack0), 0);
        check("rst_err", 32'(err0), 0);
        check("rst_busy", 32'(busy0), 0);
        check("rst_pin_sel", 32'(pin_sel0), 0);
        check("rst_pin_out", 32'(pin_out0), 0);
        check("rst_pin_oe", 32'(pin_oe0), 0);
        rst_n = 1'b1;
        @(negedge clk);

        // Write 0xA5 to address 0x0B (port 1, channel 3)
        prev = ack_cnt0;
        exp_q0.push_back({1'b0, 8'h00});
        issue0(1'b1, 16'h000B, 8'hA5, 1'b0, t0);
        check("wr_sel", 32'(pin_sel0), 32'(6'b011_000));
        check("wr_busy", 32'(busy0), 1);
        @(negedge clk);
        check("wr_oe_early", 32'(pin_oe0), 0);
        repeat (2) @(negedge clk);
        check("wr_oe", 32'(pin_oe0), 32'(2'b10));
        check("wr_out", 32'(pin_out0[15:8]), 32'h A5);
        @(negedge clk);
        check("wr_oe_drop", 32'(pin_oe0), 0);
        check("wr_out_hold", 32'(pin_out0), 32'h A500);
        wait_ack0(prev, t0, 4, "wr_lat");
        @(negedge clk);

        // Read address 0x02 (port 0, channel 2)
        prev = ack_cnt0;
        exp_q0.push_back({1'b0, 8'h3C});
        issue0(1'b0, 16'h0002, 8'h00, 1'b0, t0);
        check("rd_sel", 32'(pin_sel0), 32'(6'b011_010));
        oe_bad = 1'b0;
        repeat (4) begin
            @(negedge clk);
            if (pin_oe0 != 2'b00) oe_bad = 1'b1;
        end
        check("rd_oe", 32'(oe_bad), 0);
        wait_ack0(prev, t0, 4, "rd_lat");
        @(negedge clk);

        // Out of range address 0x10
        prev = ack_cnt0;
        exp_q0.push_back({1'b1, 8'h3C});
        issue0(1'b0, 16'h0010, 8'h00, 1'b0, t0);
        check("oor_oe", 32'(pin_oe0), 0);
        wait_ack0(prev, t0, 1, "oor_lat");
        check("oor_sel", 32'(pin_sel0), 32'(6'b011_010));
        check("oor_out", 32'(pin_out0), 32'h A500);
        @(negedge clk);

        // Back-to-back reads with req held: 0x05 then 0x0E
        prev = ack_cnt0;
        exp_q0.push_back({1'b0, 8'h3C});
        exp_q0.push_back({1'b0, 8'h9E});
        issue0(1'b0, 16'h0005, 8'h00, 1'b1, t0);
        ioaddr0 = 16'h000E;
        repeat (6) @(negedge clk);
        req0 = 1'b0;
        wait_ack0(prev + 1, t0 + 6, 4, "b2b_lat2");
        check("b2b_gap", 32'(last_ack0 - prev_ack0), 6);
        check("b2b_sel", 32'(pin_sel0), 32'(6'b110_101));
        @(negedge clk);

        // Request pulsed during SELECT of a write to 0x0A is ignored
        prev = ack_cnt0;
        exp_q0.push_back({1'b0, 8'h9E});
        issue0(1'b1, 16'h000A, 8'h11, 1'b0, t0);
        req0 = 1'b1; we0 = 1'b0; ioaddr0 = 16'h0001;
        @(negedge clk);
        req0 = 1'b0;
        wait_ack0(prev, t0, 4, "ign_lat");
        repeat (8) @(negedge clk);
        #1;
        check("ign_acks", 32'(ack_cnt0 - prev), 1);
        check("ign_sel", 32'(pin_sel0), 32'(6'b010_101));
        check("ign_out", 32'(pin_out0), 32'h 1100);

        // Reset in the middle of SELECT aborts the write
        @(negedge clk);
        prev = ack_cnt0;
        issue0(1'b1, 16'h0009, 8'h77, 1'b0, t0);
        rst_n = 1'b0;
        @(negedge clk);
        check("abort_oe", 32'(pin_oe0), 0);
        check("abort_ack", 32'(ack0), 0);
        check("abort_busy", 32'(busy0), 0);
        check("abort_sel", 32'(pin_sel0), 0);
        check("abort_out", 32'(pin_out0), 0);
        check("abort_rdata", 32'(rdata0), 0);
        rst_n = 1'b1;
        repeat (10) @(negedge clk);
        #1;
        check("abort_noack", 32'(ack_cnt0 - prev), 0);

        // Parameter sweep instance: address 11 -> port 2 channel 3, address 12 invalid
        @(negedge clk);
        prev = ack_cnt1;
        exp_q1.push_back({1'b0, 8'h5A});
        issue1(1'b0, 16'd11, 8'h00, t0);
        check("sw_sel", 32'(pin_sel1), 32'(6'b11_00_00));
        wait_ack1(prev, t0, 3, "sw_lat");
        @(negedge clk);
        prev = ack_cnt1;
        exp_q1.push_back({1'b1, 8'h5A});
        issue1(1'b0, 16'd12, 8'h00, t0);
        wait_ack1(prev, t0, 1, "sw_oor_lat");
        check("sw_oor_sel", 32'(pin_sel1), 32'(6'b11_00_00));
        check("sw_oor_oe", 32'(pin_oe1), 0);

        repeat (4) @(negedge clk);
        check("q0_drained", 32'(exp_q0.size()), 0);
        check("q1_drained", 32'(exp_q1.size()), 0);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
